usb_ep_fifo: RTL

//  Parametrised USB endpoint FIFO with packet transactions. Replaces the fixed

---
 rtl/usb_ep_fifo_pkg.sv | 46 ++++
 rtl/usb_ep_fifo_if.sv | 36 +++
 rtl/usb_ep_fifo_ram.sv | 38 +++
 rtl/usb_ep_fifo.sv | 130 +++++++++++++
 4 files changed

// File: rtl/usb_ep_fifo_pkg.sv
// Shared types for the USB endpoint FIFO: the per-cycle packet actions
// taken on each side and the priority rules that pick between them.
package usb_ep_fifo_pkg;

   // Packet-level action on the write side for one cycle
   typedef enum logic [1:0] {
      WR_HOLD   = 2'd0,
      WR_COMMIT = 2'd1,
      WR_ABORT  = 2'd2
   } wr_action_e;

   // Packet-level action on the read side for one cycle
   typedef enum logic [1:0] {
      RD_HOLD   = 2'd0,
      RD_COMMIT = 2'd1,
      RD_REWIND = 2'd2
   } rd_action_e;

   // Abort wins over commit, and a commit of an overflowed packet is an abort
   function automatic wr_action_e wr_action(input logic abort,
                                            input logic commit,
                                            input logic ovf);
      wr_action_e act;
      act = WR_HOLD;
      if (abort || (commit && ovf)) begin
         act = WR_ABORT;
      end else if (commit) begin
         act = WR_COMMIT;
      end
      return act;
   endfunction

   // Rewind (retransmit) wins over commit (ACK)
   function automatic rd_action_e rd_action(input logic rewind,
                                            input logic commit);
      rd_action_e act;
      act = RD_HOLD;
      if (rewind) begin
         act = RD_REWIND;
      end else if (commit) begin
         act = RD_COMMIT;
      end
      return act;
   endfunction

endpackage

// File: rtl/usb_ep_fifo_if.sv
// Endpoint FIFO port bundle between the SIE (master) and the FIFO (slave).
// Widths follow the instance parameters; clock and reset travel separately.
interface if_ep_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic             sclr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_req;
   logic             wr_commit;
   logic             wr_abort;
   logic             full;
   logic [AW:0]      wr_free;
   logic             wr_ovf;
   logic             rd_req;
   logic             rd_commit;
   logic             rd_rewind;
   logic [WIDTH-1:0] q;
   logic             empty;
   logic [AW:0]      usedw;

   modport master (
      output sclr, wr_data, wr_req, wr_commit, wr_abort,
      output rd_req, rd_commit, rd_rewind,
      input  full, wr_free, wr_ovf, q, empty, usedw
   );

   modport slave (
      input  sclr, wr_data, wr_req, wr_commit, wr_abort,
      input  rd_req, rd_commit, rd_rewind,
      output full, wr_free, wr_ovf, q, empty, usedw
   );

endinterface

// File: rtl/usb_ep_fifo_ram.sv
// Simple dual-port storage for the endpoint FIFO. The array itself has no
// reset; only the registered read port is cleared so q starts at zero.
module usb_ep_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the byte when the write side accepts it
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: registered output, held between reads, cleared on reset/clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (clr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/usb_ep_fifo.sv
// Packet-transaction endpoint FIFO. Writes are staged and then committed or
// aborted; reads are speculative and then released (ACK) or rewound
// (retransmit). Four wrap-around pointers carry all of the state.
module usb_ep_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input logic      clk,
   input logic      reset_n,
   if_ep_fifo.slave bus
);
   import usb_ep_fifo_pkg::*;

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_P   = (AW+1)'(1);

   logic [AW:0] wr_ptr;
   logic [AW:0] wr_cmt;
   logic [AW:0] rd_ptr;
   logic [AW:0] rd_cmt;
   logic        wr_ovf_r;

   logic [AW:0] wr_used;
   logic        full_i;
   logic        empty_i;
   logic        wr_accept;
   logic        wr_drop;
   logic        rd_accept;
   logic        ram_we;
   logic [AW:0] wr_ptr_next;
   logic [AW:0] rd_ptr_next;
   wr_action_e  wr_act;
   rd_action_e  rd_act;

   // Occupancy counts everything not yet released by the reader, so space
   // only comes back on a read commit.
   assign wr_used  = wr_ptr - rd_cmt;
   assign full_i   = (wr_used == DEPTH_P);
   assign empty_i  = (rd_ptr == wr_cmt);

   assign bus.full    = full_i;
   assign bus.wr_free = DEPTH_P - wr_used;
   assign bus.wr_ovf  = wr_ovf_r;
   assign bus.empty   = empty_i;
   assign bus.usedw   = wr_cmt - rd_ptr;

   // A drop this cycle already poisons the packet, so a same-cycle commit aborts
   assign wr_accept   = bus.wr_req & ~full_i;
   assign wr_drop     = bus.wr_req & full_i;
   assign wr_act      = wr_action(bus.wr_abort, bus.wr_commit, wr_ovf_r | wr_drop);
   assign wr_ptr_next = wr_accept ? (wr_ptr + ONE_P) : wr_ptr;
   assign ram_we      = wr_accept & ~bus.sclr & (wr_act != WR_ABORT);

   // A rewind cancels any same-cycle read so q holds its old byte
   assign rd_act      = rd_action(bus.rd_rewind, bus.rd_commit);
   assign rd_accept   = bus.rd_req & ~empty_i & ~bus.sclr & (rd_act != RD_REWIND);
   assign rd_ptr_next = rd_accept ? (rd_ptr + ONE_P) : rd_ptr;

   // Write-side pointers and the sticky overflow flag of the current packet
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         wr_cmt   <= '0;
         wr_ovf_r <= 1'b0;
      end else if (bus.sclr) begin
         wr_ptr   <= '0;
         wr_cmt   <= '0;
         wr_ovf_r <= 1'b0;
      end else begin
         case (wr_act)
            WR_ABORT: begin
               wr_ptr   <= wr_cmt;
               wr_ovf_r <= 1'b0;
            end
            WR_COMMIT: begin
               wr_ptr   <= wr_ptr_next;
               wr_cmt   <= wr_ptr_next;
               wr_ovf_r <= 1'b0;
            end
            default: begin
               wr_ptr <= wr_ptr_next;
               if (wr_drop) begin
                  wr_ovf_r <= 1'b1;
               end
            end
         endcase
      end
   end

   // Read-side pointers: speculative read pointer and the last release point
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         rd_cmt <= '0;
      end else if (bus.sclr) begin
         rd_ptr <= '0;
         rd_cmt <= '0;
      end else begin
         case (rd_act)
            RD_REWIND: begin
               rd_ptr <= rd_cmt;
            end
            RD_COMMIT: begin
               rd_ptr <= rd_ptr_next;
               rd_cmt <= rd_ptr_next;
            end
            default: begin
               rd_ptr <= rd_ptr_next;
            end
         endcase
      end
   end

   usb_ep_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (bus.sclr),
      .we      (ram_we),
      .waddr   (wr_ptr[AW-1:0]),
      .wdata   (bus.wr_data),
      .re      (rd_accept),
      .raddr   (rd_ptr[AW-1:0]),
      .rdata   (bus.q)
   );

endmodule
